// File: rtl/rand_note_picker.sv
// Rejection-sampling note picker: collects WORD_W serial random bits MSB-first.
// Emits an index in 0..MAX_VAL on a valid/ready handshake, or a fallback of 0 once retries run out.
module rand_note_picker #(
  parameter int WORD_W    = 4,
  parameter int MAX_VAL   = 11,
  parameter int MAX_RETRY = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              req,
  output logic [WORD_W-1:0] note_out,
  output logic              note_valid,
  input  logic              note_ready,
  output logic              fallback,
  output logic              busy,
  output logic [7:0]        reject_cnt
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [WORD_W-1:0] MAX_W  = WORD_W'(MAX_VAL);
  localparam logic [CNT_W-1:0]  LAST_B = CNT_W'(WORD_W - 1);
  localparam logic [RTY_W-1:0]  RTY_LIM = RTY_W'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, COLLECT, CHECK, HOLD} state_t;

  state_t            state;
  logic [WORD_W-1:0] sr;
  logic [CNT_W-1:0]  bit_cnt;
  logic [RTY_W-1:0]  retry_cnt;
  logic [RTY_W-1:0]  retry_next;

  assign retry_next = retry_cnt + 1'b1;

  // NOTE: every register here, including the shift register, sits on the async reset
  // so an abort mid-collect can never leak stale bits into the next word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      bit_cnt    <= '0;
      retry_cnt  <= '0;
      note_out   <= '0;
      note_valid <= 1'b0;
      fallback   <= 1'b0;
      busy       <= 1'b0;
      reject_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so each edge sees the pre-edge state.
      unique case (state)
        IDLE: begin
          if (req) begin
            state     <= COLLECT;
            bit_cnt   <= '0;
            retry_cnt <= '0;
            busy      <= 1'b1;
          end
        end

        COLLECT: begin
          sr      <= {sr[WORD_W-2:0], bit_in};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_B) state <= CHECK;
        end

        CHECK: begin
          if (sr <= MAX_W) begin
            note_out   <= sr;
            fallback   <= 1'b0;
            note_valid <= 1'b1;
            state      <= HOLD;
          end else begin
            if (reject_cnt != 8'hFF) reject_cnt <= reject_cnt + 8'd1;
            retry_cnt <= retry_next;
            if (retry_next == RTY_LIM) begin
              note_out   <= '0;
              fallback   <= 1'b1;
              note_valid <= 1'b1;
              state      <= HOLD;
            end else begin
              // Retry with a completely fresh word.
              bit_cnt <= '0;
              state   <= COLLECT;
            end
          end
        end

        HOLD: begin
          if (note_ready) begin
            note_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rand_note_picker.md
Name: rand_note_picker

Overview:
- Downstream consumer of the 4-bit LFSR's serial random bit `q`. One bit is sampled per clock.
- On request, assembles a WORD_W-bit word and range-limits it to a valid note index 0..MAX_VAL by rejection sampling.
- Presents the index on a valid/ready handshake to the karaoke note scheduler.
- Tracks total rejections for debug.

Parameters:
- WORD_W, 4: bits collected per candidate word. Must be ≥2.
- MAX_VAL, 11: largest accepted index, giving 12 semitones. Must satisfy MAX_VAL < 2^WORD_W.
- MAX_RETRY, 8: consecutive rejected words within one request before fallback. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- bit_in  in  1  serial random bit; connect to LFSR `q`.
- req  in  1  request a new index. Sampled only in IDLE.
- note_out  out  WORD_W  selected note index.
- note_valid  out  1  note_out valid.
- note_ready  in  1  consumer accepts note_out.
- fallback  out  1  qualifies note_out; high means the retry limit was hit and note_out=0.
- busy  out  1  high in any state other than IDLE.
- reject_cnt  out  8  saturating count of rejected words since reset.

Behaviour:
- All outputs are registered.
- Reset (asynchronous, any state, including mid-collect or mid-hold):
  - state=IDLE.
  - note_out=0, note_valid=0, fallback=0, busy=0, reject_cnt=0.
  - Shift register, bit counter and retry counter cleared.
- States: IDLE, COLLECT, CHECK, HOLD.
- IDLE:
  - req=1 at an edge → COLLECT.
  - Clear bit_cnt and retry_cnt.
  - busy goes 1 at that same edge.
- COLLECT:
  - Every edge: sr <= {sr[WORD_W-2:0], bit_in}, i.e. MSB-first; the first sampled bit ends as the MSB.
  - Every edge: bit_cnt++.
  - After WORD_W samples → CHECK.
  - bit_in is sampled on exactly WORD_W consecutive edges after the req edge.
- CHECK (one cycle):
  - sr ≤ MAX_VAL (unsigned): note_out<=sr, fallback<=0, note_valid<=1 → HOLD.
  - Else: reject_cnt<=reject_cnt+1, saturating at 255; retry_cnt++.
    - If the new retry_cnt == MAX_RETRY: note_out<=0, fallback<=1, note_valid<=1 → HOLD.
    - Otherwise: bit_cnt<=0 → COLLECT. Fresh bits are collected; sr bits are not reused.
- HOLD:
  - note_out, fallback and note_valid are held stable while note_ready=0.
  - note_valid=1 and note_ready=1 at an edge: transfer completes; note_valid<=0 and → IDLE, busy<=0.
  - note_ready is ignored when note_valid=0.
- Latency, no rejections: req sampled at edge k → note_valid rises at edge k+WORD_W+1. That is 5 cycles for WORD_W=4.
  - Each rejection adds WORD_W+1 cycles.
- req outside IDLE is ignored. It is not queued.
- req held high continuously produces back-to-back requests. Minimum spacing: one IDLE cycle after each transfer.
- Simultaneous note_ready handshake and req: the req is ignored, since the state is not IDLE at that edge.
- reject_cnt counts across requests and is cleared only by rst.

Test Plan:
1. WORD_W=4, MAX_VAL=11. req pulse at edge 0, bench drives bit_in 1,0,1,0 on edges 1-4 → note_valid=1 after edge 5, note_out=10, fallback=0, reject_cnt=0. note_ready=1 at edge 6 → note_valid=0, busy=0 after edge 6.
2. Rejection: req, then bits 1,1,1,1 (15, rejected), then 0,0,1,1 → reject_cnt=1 after the first CHECK; note_out=3 with note_valid after edge 10.
3. Fallback, MAX_RETRY=2: req, then bits 1,1,0,0 twice (12 both times) → reject_cnt=2; note_out=0, fallback=1, note_valid after edge 10.
4. Backpressure: after case 1, hold note_ready=0 for 6 cycles and pulse req during HOLD → note_out stays 10, note_valid stays 1, no new collection. Then ready=1 → IDLE. reject_cnt unchanged.
5. Reset mid-COLLECT: assert rst between edges 2 and 3 of a collect → all outputs 0 immediately, asynchronously. Release rst, then run case 1 → identical result, so no stale sr bits leak through.
6. Saturation: force 300 rejected words (bit_in=1 constantly, MAX_RETRY=8, repeated req) → reject_cnt stops at 255 and never wraps.
